// File: rtl/valu_issue_seq.sv
// valu_issue_seq -- command sequencer in front of the vector ALU block.
//
// Takes one vector-arithmetic command (opcode, SEW, vap, word count) and, for
// every 32-bit word, fetches operands, releases the ALU from reset with the
// operands held stable, waits for alu_done (bounded by TIMEOUT) and writes
// the result back. Dot-product opcodes (02, 05) feed the previous result back
// as opC, so the command reduces to a single write at word index 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, cmd_*          command strobe and fields (sampled only in IDLE)
//   busy, done, err       status; done is a one-cycle pulse, err = ALU timeout
//   op_req, op_idx        operand fetch request pulse and word index
//   op_valid, op_a/b/c    operand return
//   alu_resetn, alu_*     ALU control and operands
//   alu_out, alu_done     ALU result and completion
//   wr_en, wr_idx, wr_data result write-back
module valu_issue_seq #(
   parameter int IDXW    = 5,
   parameter int TIMEOUT = 64
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [7:0]      cmd_instr,
   input  logic [9:0]      cmd_sew,
   input  logic [3:0]      cmd_vap,
   input  logic [IDXW-1:0] cmd_nwords,
   output logic            busy,
   output logic            done,
   output logic            err,
   output logic            op_req,
   output logic [IDXW-1:0] op_idx,
   input  logic            op_valid,
   input  logic [31:0]     op_a,
   input  logic [31:0]     op_b,
   input  logic [31:0]     op_c,
   output logic            alu_resetn,
   output logic [7:0]      alu_instr,
   output logic [9:0]      alu_sew,
   output logic [3:0]      alu_vap,
   output logic [31:0]     alu_opA,
   output logic [31:0]     alu_opB,
   output logic [31:0]     alu_opC,
   input  logic [31:0]     alu_out,
   input  logic            alu_done,
   output logic            wr_en,
   output logic [IDXW-1:0] wr_idx,
   output logic [31:0]     wr_data
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
   localparam logic [IDXW-1:0] IDX_ZERO   = {IDXW{1'b0}};
   localparam logic [IDXW-1:0] IDX_ONE    = IDXW'(1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_WAIT_OP = 3'd2,
      S_EXEC    = 3'd3,
      S_WRITE   = 3'd4,
      S_FIN     = 3'd5
   } state_t;

   // Dot-product opcodes accumulate across words.
   function automatic logic is_acc(input logic [7:0] op);
      return (op == 8'h02) || (op == 8'h05);
   endfunction

   state_t          state_q, state_d;
   logic            busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic            op_req_q, op_req_d, alu_resetn_q, alu_resetn_d, wr_en_q, wr_en_d;
   logic [IDXW-1:0] op_idx_q, op_idx_d, wr_idx_q, wr_idx_d;
   logic [IDXW-1:0] idx_q, idx_d, nwords_q, nwords_d;
   logic [7:0]      alu_instr_q, alu_instr_d, instr_q, instr_d;
   logic [9:0]      alu_sew_q, alu_sew_d, sew_q, sew_d;
   logic [3:0]      alu_vap_q, alu_vap_d, vap_q, vap_d;
   logic [31:0]     alu_opa_q, alu_opa_d, alu_opb_q, alu_opb_d, alu_opc_q, alu_opc_d;
   logic [31:0]     wr_data_q, wr_data_d, result_q, result_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic            last_word_s;

   assign last_word_s = (idx_q == (nwords_q - IDX_ONE));

   // Next-state and registered-output computation.
   always_comb begin
      state_d      = state_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_d        = err_q;
      op_req_d     = 1'b0;
      op_idx_d     = op_idx_q;
      alu_resetn_d = alu_resetn_q;
      alu_instr_d  = alu_instr_q;
      alu_sew_d    = alu_sew_q;
      alu_vap_d    = alu_vap_q;
      alu_opa_d    = alu_opa_q;
      alu_opb_d    = alu_opb_q;
      alu_opc_d    = alu_opc_q;
      wr_en_d      = 1'b0;
      wr_idx_d     = wr_idx_q;
      wr_data_d    = wr_data_q;
      idx_d        = idx_q;
      nwords_d     = nwords_q;
      instr_d      = instr_q;
      sew_d        = sew_q;
      vap_d        = vap_q;
      result_d     = result_q;
      timer_d      = timer_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               instr_d  = cmd_instr;
               sew_d    = cmd_sew;
               vap_d    = cmd_vap;
               nwords_d = cmd_nwords;
               idx_d    = IDX_ZERO;
               busy_d   = 1'b1;
               err_d    = 1'b0;
               if (cmd_nwords == IDX_ZERO) begin
                  state_d = S_FIN;
               end else begin
                  // Request is raised on entry so op_req is high while in FETCH.
                  state_d  = S_FETCH;
                  op_req_d = 1'b1;
                  op_idx_d = IDX_ZERO;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            state_d = S_WAIT_OP;
         end
         S_WAIT_OP: begin
            if (op_valid) begin
               alu_opa_d    = op_a;
               alu_opb_d    = op_b;
               alu_opc_d    = (is_acc(instr_q) && (idx_q != IDX_ZERO)) ? result_q : op_c;
               alu_instr_d  = instr_q;
               alu_sew_d    = sew_q;
               alu_vap_d    = vap_q;
               timer_d      = {TW{1'b0}};
               alu_resetn_d = 1'b1;
               state_d      = S_EXEC;
            end else begin
               state_d = S_WAIT_OP;
            end
         end
         S_EXEC: begin
            // alu_done has priority over a coincident timeout.
            if (alu_done) begin
               result_d     = alu_out;
               alu_resetn_d = 1'b0;
               state_d      = S_WRITE;
               if (!is_acc(instr_q)) begin
                  wr_en_d   = 1'b1;
                  wr_idx_d  = idx_q;
                  wr_data_d = alu_out;
               end else if (last_word_s) begin
                  wr_en_d   = 1'b1;
                  wr_idx_d  = IDX_ZERO;
                  wr_data_d = alu_out;
               end else begin
                  wr_en_d = 1'b0;
               end
            end else if (timer_q == TIMER_LAST) begin
               alu_resetn_d = 1'b0;
               err_d        = 1'b1;
               state_d      = S_FIN;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_WRITE: begin
            if (last_word_s) begin
               state_d = S_FIN;
            end else begin
               idx_d    = idx_q + IDX_ONE;
               op_req_d = 1'b1;
               op_idx_d = idx_q + IDX_ONE;
               state_d  = S_FETCH;
            end
         end
         S_FIN: begin
            // done and the busy drop both appear in the cycle after FIN.
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            state_d      = S_IDLE;
            busy_d       = 1'b0;
            alu_resetn_d = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         op_req_q     <= 1'b0;
         op_idx_q     <= IDX_ZERO;
         alu_resetn_q <= 1'b0;
         alu_instr_q  <= 8'd0;
         alu_sew_q    <= 10'd0;
         alu_vap_q    <= 4'd0;
         alu_opa_q    <= 32'd0;
         alu_opb_q    <= 32'd0;
         alu_opc_q    <= 32'd0;
         wr_en_q      <= 1'b0;
         wr_idx_q     <= IDX_ZERO;
         wr_data_q    <= 32'd0;
         idx_q        <= IDX_ZERO;
         nwords_q     <= IDX_ZERO;
         instr_q      <= 8'd0;
         sew_q        <= 10'd0;
         vap_q        <= 4'd0;
         result_q     <= 32'd0;
         timer_q      <= {TW{1'b0}};
      end else begin
         state_q      <= state_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         op_req_q     <= op_req_d;
         op_idx_q     <= op_idx_d;
         alu_resetn_q <= alu_resetn_d;
         alu_instr_q  <= alu_instr_d;
         alu_sew_q    <= alu_sew_d;
         alu_vap_q    <= alu_vap_d;
         alu_opa_q    <= alu_opa_d;
         alu_opb_q    <= alu_opb_d;
         alu_opc_q    <= alu_opc_d;
         wr_en_q      <= wr_en_d;
         wr_idx_q     <= wr_idx_d;
         wr_data_q    <= wr_data_d;
         idx_q        <= idx_d;
         nwords_q     <= nwords_d;
         instr_q      <= instr_d;
         sew_q        <= sew_d;
         vap_q        <= vap_d;
         result_q     <= result_d;
         timer_q      <= timer_d;
      end
   end

   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign op_req     = op_req_q;
   assign op_idx     = op_idx_q;
   assign alu_resetn = alu_resetn_q;
   assign alu_instr  = alu_instr_q;
   assign alu_sew    = alu_sew_q;
   assign alu_vap    = alu_vap_q;
   assign alu_opA    = alu_opa_q;
   assign alu_opB    = alu_opb_q;
   assign alu_opC    = alu_opc_q;
   assign wr_en      = wr_en_q;
   assign wr_idx     = wr_idx_q;
   assign wr_data    = wr_data_q;

endmodule
